bram_to_stream: RTL and testbench

//  Downstream consumer of the double-handshake BRAM cast buffer. Waits for the buffer's

---
 rtl/cast_pkg.sv | 9 +
 rtl/bram_to_stream_if.sv | 29 ++
 rtl/bram_to_stream_fifo.sv | 62 ++++++
 rtl/bram_to_stream.sv | 101 ++++++++++
 tb/tb_bram_to_stream.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cast_pkg.sv
// Shared types and constants for the BRAM-to-stream reader.
package cast_pkg;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, RELEASE} b2s_state_t;

  localparam int B2S_FIFO_DEPTH = 2;
  localparam int B2S_CNT_W      = $clog2(B2S_FIFO_DEPTH + 1);

endpackage

// File: rtl/bram_to_stream_if.sv
// Buffer read-port and output-stream signals of the BRAM-to-stream reader.
interface bram_to_stream_if #(
  parameter int IN_WIDTH   = 8,
  parameter int ADDR_WIDTH = 7
);

  logic                  buf_start;
  logic                  buf_ready;
  logic [ADDR_WIDTH-1:0] address0;
  logic                  ce0;
  logic [IN_WIDTH-1:0]   q0;
  logic [IN_WIDTH-1:0]   data_out;
  logic                  data_out_valid;
  logic                  data_out_ready;
  logic                  data_out_last;

  // Stream: a word transfers on a clock edge where data_out_valid and data_out_ready are both
  // high; once valid is raised, data/last stay stable and valid stays high until that edge.
  modport master (
    input  buf_start, q0, data_out_ready,
    output buf_ready, address0, ce0, data_out, data_out_valid, data_out_last
  );

  modport slave (
    output buf_start, q0, data_out_ready,
    input  buf_ready, address0, ce0, data_out, data_out_valid, data_out_last
  );

endinterface

// File: rtl/bram_to_stream_fifo.sv
// Two-entry shift FIFO; slot 0 is always the head, so the head is a plain register.
module bram_to_stream_fifo
  import cast_pkg::*;
#(
  parameter int W = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic [W-1:0]         din_i,
  input  logic                 pop_i,
  output logic [W-1:0]         head_o,
  output logic                 head_vld_o,
  output logic [B2S_CNT_W-1:0] count_o
);

  logic [W-1:0] mem0_q, mem0_d;
  logic [W-1:0] mem1_q, mem1_d;
  logic         vld0_q, vld0_d;
  logic         vld1_q, vld1_d;

  always_comb begin
    mem0_d = mem0_q;
    mem1_d = mem1_q;
    vld0_d = vld0_q;
    vld1_d = vld1_q;
    if (pop_i && vld0_q) begin
      mem0_d = mem1_q;
      vld0_d = vld1_q;
      vld1_d = 1'b0;
    end
    // Push lands in the first free slot after any pop has shifted the queue.
    if (push_i) begin
      if (!vld0_d) begin
        mem0_d = din_i;
        vld0_d = 1'b1;
      end else begin
        mem1_d = din_i;
        vld1_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem0_q <= '0;
      mem1_q <= '0;
      vld0_q <= 1'b0;
      vld1_q <= 1'b0;
    end else begin
      mem0_q <= mem0_d;
      mem1_q <= mem1_d;
      vld0_q <= vld0_d;
      vld1_q <= vld1_d;
    end
  end

  assign head_o     = mem0_q;
  assign head_vld_o = vld0_q;
  assign count_o    = B2S_CNT_W'(vld0_q) + B2S_CNT_W'(vld1_q);

endmodule

// File: rtl/bram_to_stream.sv
// Reads one frame from the cast buffer's read port and emits it as a valid/ready stream,
// then pulses buf_ready so the producer can refill the buffer.
module bram_to_stream
  import cast_pkg::*;
#(
  parameter int IN_WIDTH   = 8,
  parameter int ADDR_RANGE = 100,
  parameter int ADDR_WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  bram_to_stream_if.master bus,
  output b2s_state_t       dbg_state_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ADDR_RANGE - 1);

  b2s_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  inflight_q, inflight_d;
  logic                  pend_last_q, pend_last_d;

  logic [IN_WIDTH:0]     head;
  logic                  head_vld;
  logic [B2S_CNT_W-1:0]  fifo_count;
  logic                  pop;
  logic                  issue;
  logic                  at_last;
  logic [2:0]            used;

  assign pop     = head_vld & bus.data_out_ready;
  assign at_last = (cnt_q == LAST_ADDR);
  // Slots already claimed (in flight or stored) after this cycle's pop; a new read needs a free one.
  assign used    = 3'(inflight_q) + 3'(fifo_count) - 3'(pop);
  assign issue   = (state_q == READ) && (used < 3'(B2S_FIFO_DEPTH));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    inflight_d  = issue;
    pend_last_d = issue ? at_last : pend_last_q;
    case (state_q)
      IDLE: begin
        if (bus.buf_start) state_d = READ;
      end
      READ: begin
        if (issue) begin
          if (at_last) state_d = DRAIN;
          else         cnt_d   = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (fifo_count == '0 && !inflight_q) state_d = RELEASE;
      end
      RELEASE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      inflight_q  <= 1'b0;
      pend_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      inflight_q  <= inflight_d;
      pend_last_q <= pend_last_d;
    end
  end

  bram_to_stream_fifo #(
    .W (IN_WIDTH + 1)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (inflight_q),
    .din_i      ({pend_last_q, bus.q0}),
    .pop_i      (pop),
    .head_o     (head),
    .head_vld_o (head_vld),
    .count_o    (fifo_count)
  );

  assign bus.ce0            = issue;
  assign bus.address0       = cnt_q;
  assign bus.buf_ready      = (state_q == RELEASE);
  assign bus.data_out       = head[IN_WIDTH-1:0];
  assign bus.data_out_last  = head[IN_WIDTH];
  assign bus.data_out_valid = head_vld;
  assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_bram_to_stream.sv
// Bench for bram_to_stream: buffer models, ready driver, scoreboard and directed/random frames.
module tb_bram_to_stream;
  import cast_pkg::*;

  localparam int W  = 8;
  localparam int R  = 4;
  localparam int AW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  int   edge_cnt = 0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  bram_to_stream_if #(.IN_WIDTH(W), .ADDR_WIDTH(AW)) bus ();
  bram_to_stream_if #(.IN_WIDTH(W), .ADDR_WIDTH(1))  bus1 ();
  b2s_state_t dbg0, dbg1;

  bram_to_stream #(.IN_WIDTH(W), .ADDR_RANGE(R), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state_o(dbg0)
  );
  bram_to_stream #(.IN_WIDTH(W), .ADDR_RANGE(1), .ADDR_WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .dbg_state_o(dbg1)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- buffer models (registered q0 = A0 + addr, start/ready handshake) ----------------
  int loaded0 = 0, given0 = 0;
  int loaded1 = 0, given1 = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.buf_start <= 1'b0;
      bus.q0        <= '0;
      given0        <= loaded0;
    end else begin
      if (bus.ce0) bus.q0 <= 8'hA0 + 8'(bus.address0);
      if (bus.buf_start && bus.buf_ready) bus.buf_start <= 1'b0;
      else if (!bus.buf_start && given0 < loaded0) begin
        bus.buf_start <= 1'b1;
        given0        <= given0 + 1;
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus1.buf_start <= 1'b0;
      bus1.q0        <= '0;
      given1         <= loaded1;
    end else begin
      if (bus1.ce0) bus1.q0 <= 8'hA0 + 8'(bus1.address0);
      if (bus1.buf_start && bus1.buf_ready) bus1.buf_start <= 1'b0;
      else if (!bus1.buf_start && given1 < loaded1) begin
        bus1.buf_start <= 1'b1;
        given1         <= given1 + 1;
      end
    end
  end

  // ---------------- ready driver: 0 always, 1 ten-cycle stall at first valid, 2 toggle, 3 random ----------------
  int ready_mode = 0;
  initial begin
    int stall_cnt;
    stall_cnt = 0;
    bus.data_out_ready  = 1'b1;
    bus1.data_out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: begin
          if (stall_cnt < 10 && bus.data_out_valid) begin
            bus.data_out_ready = 1'b0;
            stall_cnt++;
          end else begin
            bus.data_out_ready = 1'b1;
          end
        end
        2: bus.data_out_ready = ~bus.data_out_ready;
        3: bus.data_out_ready = 1'($urandom_range(0, 1));
        default: bus.data_out_ready = 1'b1;
      endcase
      if (ready_mode != 1) stall_cnt = 0;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [W:0] exp_q[$];
  bit         exp_busy = 0;
  int         exp_addr = 0;
  int         outstanding = 0;
  int         max_outst = 0;
  int         frame_acc = 0;
  int         rel_count = 0;
  int         e0 = 0;
  int         first_ce_cyc = -1;
  int         acc_cyc[$];
  int         rel_cyc[$];
  bit         prev_hold = 0;
  logic [W:0] prev_word;

  always @(negedge clk) begin
    logic [W:0] word;
    int         cyc;
    bit         pop;
    word = {bus.data_out_last, bus.data_out};
    cyc  = edge_cnt - e0 + 1;
    pop  = bus.data_out_valid && bus.data_out_ready;
    if (rst) begin
      exp_q.delete();
      exp_busy    = 0;
      exp_addr    = 0;
      outstanding = 0;
      frame_acc   = 0;
      prev_hold   = 0;
    end else begin
      if (prev_hold) begin
        check_eq("hold_valid", 32'(bus.data_out_valid), 1);
        check_eq("hold_word", 32'(word), 32'(prev_word));
      end
      if (bus.ce0) begin
        check_eq("ce0_in_frame", 32'(exp_busy), 1);
        check_eq("addr", 32'(bus.address0), exp_addr);
        if (exp_addr == 0) first_ce_cyc = cyc;
        exp_addr++;
      end
      if (pop) begin
        if (exp_q.size() == 0) check_eq("extra_word", exp_q.size(), 1);
        else check_eq("word", 32'(word), 32'(exp_q.pop_front()));
        acc_cyc.push_back(cyc);
        frame_acc++;
      end
      outstanding = outstanding + int'(bus.ce0) - int'(pop);
      if (outstanding > max_outst) max_outst = outstanding;
      if (bus.ce0) check_eq("credit", 32'(outstanding > 2), 0);
      if (!exp_busy && bus.buf_start) begin
        exp_busy = 1;
        e0       = edge_cnt + 1;
        for (int a = 0; a < R; a++) exp_q.push_back({(a == R - 1), W'(32'hA0 + a)});
      end else if (bus.buf_ready) begin
        check_eq("rel_words", frame_acc, R);
        check_eq("rel_outst", outstanding, 0);
        rel_cyc.push_back(cyc);
        rel_count++;
        exp_busy  = 0;
        exp_addr  = 0;
        frame_acc = 0;
      end
      prev_hold = bus.data_out_valid && !bus.data_out_ready;
      prev_word = word;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_release(input int target);
    int n;
    n = 0;
    while (rel_count < target && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("release_seen", rel_count, target);
    check_eq("sb_empty", exp_q.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_b0"}, {bus.ce0, bus.buf_ready, bus.data_out_valid, bus.data_out_last,
                            6'(bus.address0), bus.data_out}, 0);
    check_eq({tag, "_b1"}, {bus1.ce0, bus1.buf_ready, bus1.data_out_valid, bus1.data_out_last,
                            bus1.address0, bus1.data_out}, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int rels;
    int w1, r1;
    rels = 0;
    rst  = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    #1 rst = 1'b0;

    // 1: full-rate frame with exact cycle positions
    ready_mode = 0;
    acc_cyc.delete();
    rel_cyc.delete();
    @(negedge clk);
    #1 loaded0++;
    rels++;
    wait_release(rels);
    check_eq("t1_first_ce_cyc", first_ce_cyc, 1);
    check_eq("t1_acc_n", acc_cyc.size(), 4);
    for (int i = 0; i < 4 && i < acc_cyc.size(); i++) check_eq("t1_acc_cyc", acc_cyc[i], 3 + i);
    check_eq("t1_rel_n", rel_cyc.size(), 1);
    if (rel_cyc.size() > 0) check_eq("t1_rel_cyc", rel_cyc[0], 8);

    // 2: ten-cycle stall at first valid
    ready_mode = 1;
    max_outst  = 0;
    #1 loaded0++;
    rels++;
    wait_release(rels);
    check_eq("t2_max_outst", max_outst, 2);

    // 3: toggling ready
    ready_mode = 2;
    #1 loaded0++;
    rels++;
    wait_release(rels);

    // 4: two back-to-back frames
    ready_mode = 0;
    #1 loaded0 += 2;
    rels += 2;
    wait_release(rels);

    // random ready with random gaps between frames
    ready_mode = 3;
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      #1 loaded0++;
      rels++;
      wait_release(rels);
    end
    ready_mode = 0;

    // 5: single-word frame
    w1 = 0;
    r1 = 0;
    #1 loaded1++;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus1.ce0) check_eq("t5_addr", 32'(bus1.address0), 0);
      if (bus1.data_out_valid) begin
        check_eq("t5_data", 32'(bus1.data_out), 32'hA0);
        check_eq("t5_last", 32'(bus1.data_out_last), 1);
        w1++;
      end
      if (bus1.buf_ready) r1++;
    end
    check_eq("t5_words", w1, 1);
    check_eq("t5_release", r1, 1);

    // 6: reset in READ after two words, then a clean restart
    #1 loaded0++;
    for (int i = 0; i < 100 && frame_acc < 2; i++) begin
      @(negedge clk);
      #1;
    end
    check_eq("t6_two_words", frame_acc, 2);
    check_eq("t6_in_read", 32'(bus.ce0), 1);
    rst = 1'b1;
    #1;
    check_outputs_zero("t6_async");
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    loaded0++;
    rels++;
    wait_release(rels);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
